cpu_top: RTL and testbench

CPU_TOP -- requirements
Module: cpu_top

---
 rtl/cpu_top.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_cpu_top.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_top.sv
// ---------------------------------------------------------------------------
// cpu_top -- single-cycle RV32I subset core with on-chip instruction and data
// memories. Every rising clk edge fetches, executes and retires one
// instruction.
//
// Ports:
//   clk      in  1  single clock, all state updates on the rising edge
//   reset_n  in  1  asynchronous active-low reset; clears pc, the register
//                   file and data memory (instruction memory is preserved)
//
// Hierarchical observation points:
//   fetch_unit.instruction_memory, fetch_unit.pc, reg_file.regs, data_memory
//
// Handshake: the core has no valid/ready interfaces; each cycle is one
// retired instruction, with no stalls or back-pressure.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cpu_fetch -- program counter and instruction memory.
//   clk, reset_n   clock / asynchronous active-low reset
//   next_pc        pc to take on the next rising edge
//   load_en/addr/  word-write port for the instruction memory. The core ties
//   load_data      it off; programs are normally placed by hierarchical
//                  assignment.
//   cur_pc         current pc (byte address)
//   instr          instruction word at cur_pc
// ---------------------------------------------------------------------------
module cpu_fetch #(
    parameter int IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_pc,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] cur_pc,
    output logic [31:0] instr
);
    localparam int IMEM_AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    reg [31:0] instruction_memory [0:IMEM_WORDS-1];
    reg [31:0] pc;

    logic [IMEM_AW-1:0] fetch_idx;
    logic [IMEM_AW-1:0] load_idx;

    // pc is a byte address; the word index wraps around the memory depth.
    assign fetch_idx = IMEM_AW'((pc >> 2) % IMEM_WORDS);
    assign load_idx  = IMEM_AW'(load_addr % IMEM_WORDS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= 32'h0;
        end else begin
            pc <= next_pc;
        end
    end

    // Instruction memory has no reset: its contents survive reset_n.
    always @(posedge clk) begin
        if (load_en) begin
            instruction_memory[load_idx] <= load_data;
        end
    end

    assign cur_pc = pc;
    assign instr  = instruction_memory[fetch_idx];
endmodule

// ---------------------------------------------------------------------------
// cpu_regfile -- 32 x 32-bit register file, two combinational read ports and
// one write port. x0 is never written and always reads 0.
//   rs1_addr/rs2_addr -> rs1_data/rs2_data   combinational reads
//   we, rd_addr, rd_data                     write on rising edge
// ---------------------------------------------------------------------------
module cpu_regfile (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data
);
    reg [31:0] regs [0:31];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (we && (rd_addr != 5'd0)) begin
            regs[rd_addr] <= rd_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : regs[rs2_addr];
endmodule

// ---------------------------------------------------------------------------
// cpu_top -- decode, execute, data memory and write-back.
// ---------------------------------------------------------------------------
module cpu_top #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input logic clk,
    input logic reset_n
);
    localparam int DMEM_AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    reg [31:0] data_memory [0:DMEM_WORDS-1];

    logic [31:0] instr;
    logic [31:0] cur_pc;
    logic [31:0] next_pc;
    logic [31:0] seq_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] rd_data;
    logic        reg_we;
    logic        dmem_we;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] mem_off;
    logic [31:0] load_data;
    logic [DMEM_AW-1:0] dmem_idx;
    logic        r_f7_ok;
    logic        i_f7_ok;
    logic        taken;

    cpu_fetch #(.IMEM_WORDS(IMEM_WORDS)) fetch_unit (
        .clk       (clk),
        .reset_n   (reset_n),
        .next_pc   (next_pc),
        .load_en   (1'b0),
        .load_addr (32'h0),
        .load_data (32'h0),
        .cur_pc    (cur_pc),
        .instr     (instr)
    );

    cpu_regfile reg_file (
        .clk      (clk),
        .reset_n  (reset_n),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (reg_we),
        .rd_addr  (rd),
        .rd_data  (rd_data)
    );

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Sequential flow wraps the 1 KiB program space back to address 0.
    assign seq_pc = (cur_pc == 32'h0000_03FC) ? 32'h0 : cur_pc + 32'd4;

    // Loads and stores share one address adder; addr[1:0] is dropped and the
    // word index wraps around the data memory depth.
    assign mem_off   = (opcode == OP_STORE) ? imm_s : imm_i;
    assign dmem_idx  = DMEM_AW'(((rs1_data + mem_off) >> 2) % DMEM_WORDS);
    assign load_data = data_memory[dmem_idx];

    // Alternate funct7 only selects SUB / SRA; any other funct7 is unsupported.
    assign r_f7_ok = (funct7 == 7'd0) ||
                     ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    assign i_f7_ok = !((funct3 == 3'b001) && (funct7 != 7'd0)) &&
                     !((funct3 == 3'b101) && (funct7 != 7'd0) && (funct7 != F7_ALT));

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (rs1_data == rs2_data);
            3'b001:  taken = (rs1_data != rs2_data);
            3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        reg_we  = 1'b0;
        dmem_we = 1'b0;
        rd_data = 32'h0;
        next_pc = seq_pc;
        case (opcode)
            OP_R: begin
                reg_we = r_f7_ok;
                case (funct3)
                    3'b000:  rd_data = (funct7 == F7_ALT) ? rs1_data - rs2_data
                                                          : rs1_data + rs2_data;
                    3'b001:  rd_data = rs1_data << rs2_data[4:0];
                    3'b010:  rd_data = {31'b0, $signed(rs1_data) < $signed(rs2_data)};
                    3'b100:  rd_data = rs1_data ^ rs2_data;
                    3'b101:  rd_data = (funct7 == F7_ALT)
                                       ? 32'($signed(rs1_data) >>> rs2_data[4:0])
                                       : rs1_data >> rs2_data[4:0];
                    3'b110:  rd_data = rs1_data | rs2_data;
                    3'b111:  rd_data = rs1_data & rs2_data;
                    default: reg_we  = 1'b0;
                endcase
            end
            OP_I: begin
                reg_we = i_f7_ok;
                case (funct3)
                    3'b000:  rd_data = rs1_data + imm_i;
                    3'b001:  rd_data = rs1_data << rs2;
                    3'b010:  rd_data = {31'b0, $signed(rs1_data) < $signed(imm_i)};
                    3'b100:  rd_data = rs1_data ^ imm_i;
                    3'b101:  rd_data = (funct7 == F7_ALT)
                                       ? 32'($signed(rs1_data) >>> rs2)
                                       : rs1_data >> rs2;
                    3'b110:  rd_data = rs1_data | imm_i;
                    3'b111:  rd_data = rs1_data & imm_i;
                    default: reg_we  = 1'b0;
                endcase
            end
            OP_LUI: begin
                reg_we  = 1'b1;
                rd_data = imm_u;
            end
            OP_AUIPC: begin
                reg_we  = 1'b1;
                rd_data = cur_pc + imm_u;
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    reg_we  = 1'b1;
                    rd_data = load_data;
                end
            end
            OP_STORE: begin
                dmem_we = (funct3 == 3'b010);
            end
            OP_BRANCH: begin
                if (taken) begin
                    next_pc = cur_pc + imm_b;
                end
            end
            OP_JAL: begin
                reg_we  = 1'b1;
                rd_data = cur_pc + 32'd4;
                next_pc = cur_pc + imm_j;
            end
            OP_JALR: begin
                reg_we  = 1'b1;
                rd_data = cur_pc + 32'd4;
                next_pc = (rs1_data + imm_i) & ~32'd1;
            end
            default: begin
                // Unsupported encodings, including all-zero words, retire as NOP.
                reg_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                data_memory[i] <= 32'h0;
            end
        end else if (dmem_we) begin
            data_memory[dmem_idx] <= rs2_data;
        end
    end
endmodule

// File: tb/tb_cpu_top.sv
// ---------------------------------------------------------------------------
// tb_cpu_top -- self-checking bench for cpu_top. Programs are written into
// instruction memory hierarchically; expected architectural state is queued
// when a program is set up and compared once the core has run it.
// ---------------------------------------------------------------------------
module tb_cpu_top;
    localparam int HALF = 50;
    localparam logic [31:0] OPR   = 32'h33;
    localparam logic [31:0] OPI   = 32'h13;
    localparam logic [31:0] LUI   = 32'h37;
    localparam logic [31:0] AUIPC = 32'h17;
    localparam logic [31:0] LOAD  = 32'h03;
    localparam logic [31:0] JALR  = 32'h67;
    localparam int P_REG  = 0;
    localparam int P_DMEM = 1000;
    localparam int P_PC   = 2000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    int          probe_q[$];
    string       tag_q[$];

    cpu_top #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk     (clk),
        .reset_n (reset_n)
    );

    // ---------------- clock / reset ----------------
    always #HALF clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR[6:0]};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [31:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                          input logic [31:0] op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    // ---------------- checking / scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] probe_read(input int p);
        if (p >= P_PC) return dut.fetch_unit.pc;
        if (p >= P_DMEM) return dut.data_memory[p - P_DMEM];
        return dut.reg_file.regs[p - P_REG];
    endfunction

    task automatic expect_val(input string tag, input int probe, input logic [31:0] v);
        tag_q.push_back(tag);
        probe_q.push_back(probe);
        exp_q.push_back(v);
    endtask

    task automatic expect_reg(input string tag, input int idx, input logic [31:0] v);
        expect_val($sformatf("%s x%0d", tag, idx), P_REG + idx, v);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            check_eq(tag_q.pop_front(), probe_read(probe_q.pop_front()), exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic put(input int a, input logic [31:0] w);
        dut.fetch_unit.instruction_memory[a] = w;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.fetch_unit.instruction_memory[i] = 32'h0;
    endtask

    // Assert reset at a falling edge and confirm state cleared with no clock edge.
    task automatic enter_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        expect_val({tag, " rst pc"}, P_PC, 32'h0);
        expect_val({tag, " rst x1"}, P_REG + 1, 32'h0);
        expect_val({tag, " rst x2"}, P_REG + 2, 32'h0);
        expect_val({tag, " rst dmem1"}, P_DMEM + 1, 32'h0);
        drain();
    endtask

    task automatic leave_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sa;
        logic [31:0] sb;

        // add sequence
        enter_reset("t_add");
        clear_imem();
        put(0, 32'h00500093);
        put(1, 32'h00300113);
        put(2, 32'h002081B3);
        leave_reset();
        run(3);
        expect_reg("t_add", 1, 32'd5);
        expect_reg("t_add", 2, 32'd3);
        expect_reg("t_add", 3, 32'd8);
        expect_val("t_add pc", P_PC, 32'h00C);
        drain();

        // negative immediate, write to x0 discarded
        enter_reset("t_x0");
        clear_imem();
        put(0, 32'hFFF00093);
        put(1, 32'h00100013);
        leave_reset();
        run(2);
        expect_reg("t_x0", 1, 32'hFFFF_FFFF);
        expect_reg("t_x0", 0, 32'h0);
        expect_val("t_x0 pc", P_PC, 32'h008);
        drain();

        // store then load
        enter_reset("t_mem");
        clear_imem();
        put(0, 32'h02A00093);
        put(1, 32'h00102223);
        put(2, 32'h00402103);
        leave_reset();
        run(3);
        expect_val("t_mem dmem1", P_DMEM + 1, 32'd42);
        expect_reg("t_mem", 2, 32'd42);
        drain();

        // mid-program reset clears memory and registers at once
        #9;
        reset_n = 1'b0;
        #5;
        expect_val("t_mem pulse dmem1", P_DMEM + 1, 32'h0);
        expect_reg("t_mem pulse", 1, 32'h0);
        expect_reg("t_mem pulse", 2, 32'h0);
        expect_val("t_mem pulse pc", P_PC, 32'h0);
        drain();
        #40;
        reset_n = 1'b1;
        run(1);
        expect_reg("t_mem restart", 1, 32'd42);
        expect_val("t_mem restart pc", P_PC, 32'h004);
        drain();

        // taken branch skips one word
        enter_reset("t_beq");
        clear_imem();
        put(0, 32'h00000463);
        put(1, 32'h00100093);
        put(2, 32'h00200113);
        leave_reset();
        run(2);
        expect_reg("t_beq", 1, 32'h0);
        expect_reg("t_beq", 2, 32'd2);
        expect_val("t_beq pc", P_PC, 32'h00C);
        drain();

        // all-zero memory: three NOPs, then an asynchronous reset pulse
        enter_reset("t_nop");
        clear_imem();
        leave_reset();
        run(3);
        expect_val("t_nop pc", P_PC, 32'h00C);
        drain();
        #9;
        reset_n = 1'b0;
        #5;
        expect_val("t_nop pulse pc", P_PC, 32'h0);
        drain();
        #40;
        reset_n = 1'b1;
        run(1);
        expect_val("t_nop restart pc", P_PC, 32'h004);
        drain();

        // ALU coverage
        enter_reset("t_alu");
        clear_imem();
        put(0,  enc_i(-7, 0, 0, 1, OPI));
        put(1,  enc_i(3, 0, 0, 2, OPI));
        put(2,  enc_r(32, 2, 1, 0, 3));
        put(3,  enc_r(0, 2, 1, 7, 4));
        put(4,  enc_r(0, 2, 1, 6, 5));
        put(5,  enc_r(0, 2, 1, 4, 6));
        put(6,  enc_r(0, 2, 1, 2, 7));
        put(7,  enc_r(0, 2, 2, 1, 8));
        put(8,  enc_r(0, 2, 1, 5, 9));
        put(9,  enc_r(32, 2, 1, 5, 10));
        put(10, enc_i(-1, 2, 2, 11, OPI));
        put(11, enc_i(-1, 1, 4, 12, OPI));
        put(12, enc_i(16, 2, 6, 13, OPI));
        put(13, enc_i(240, 1, 7, 14, OPI));
        put(14, enc_i(31, 2, 1, 15, OPI));
        put(15, enc_i(4, 15, 5, 16, OPI));
        put(16, enc_i(1028, 15, 5, 17, OPI));
        put(17, enc_u(32'h12345, 18, LUI));
        put(18, enc_u(32'h00001, 19, AUIPC));
        put(19, enc_r(0, 15, 15, 0, 20));
        put(20, 32'h0);
        put(21, enc_i(5, 1, 0, 22, 32'h7F));
        put(22, enc_s(0, 1, 0, 0));
        leave_reset();
        run(23);
        expect_reg("t_alu addi", 1, 32'hFFFF_FFF9);
        expect_reg("t_alu sub", 3, 32'hFFFF_FFF6);
        expect_reg("t_alu and", 4, 32'h0000_0001);
        expect_reg("t_alu or", 5, 32'hFFFF_FFFB);
        expect_reg("t_alu xor", 6, 32'hFFFF_FFFA);
        expect_reg("t_alu slt", 7, 32'h0000_0001);
        expect_reg("t_alu sll", 8, 32'h0000_0018);
        expect_reg("t_alu srl", 9, 32'h1FFF_FFFF);
        expect_reg("t_alu sra", 10, 32'hFFFF_FFFF);
        expect_reg("t_alu slti", 11, 32'h0);
        expect_reg("t_alu xori", 12, 32'h0000_0006);
        expect_reg("t_alu ori", 13, 32'h0000_0013);
        expect_reg("t_alu andi", 14, 32'h0000_00F0);
        expect_reg("t_alu slli", 15, 32'h8000_0000);
        expect_reg("t_alu srli", 16, 32'h0800_0000);
        expect_reg("t_alu srai", 17, 32'hF800_0000);
        expect_reg("t_alu lui", 18, 32'h1234_5000);
        expect_reg("t_alu auipc", 19, 32'h0000_1048);
        expect_reg("t_alu wrap", 20, 32'h0);
        expect_reg("t_alu badop", 22, 32'h0);
        expect_val("t_alu sb ignored", P_DMEM + 0, 32'h0);
        expect_val("t_alu pc", P_PC, 32'h05C);
        drain();

        // control flow: branches, jal, jalr, aligned-down memory access
        enter_reset("t_ctl");
        clear_imem();
        put(0,  enc_i(5, 0, 0, 1, OPI));
        put(1,  enc_i(-3, 0, 0, 2, OPI));
        put(2,  enc_b(8, 2, 1, 1));
        put(3,  enc_i(99, 0, 0, 10, OPI));
        put(4,  enc_b(8, 1, 2, 4));
        put(5,  enc_i(99, 0, 0, 11, OPI));
        put(6,  enc_b(8, 1, 2, 5));
        put(7,  enc_i(7, 0, 0, 3, OPI));
        put(8,  enc_b(8, 2, 1, 0));
        put(9,  enc_j(12, 4));
        put(10, enc_i(99, 0, 0, 12, OPI));
        put(11, enc_i(99, 0, 0, 13, OPI));
        put(12, enc_i(100, 1, 0, 5, JALR));
        put(26, enc_s(-4, 2, 1, 2));
        put(27, enc_i(-2, 1, 2, 6, LOAD));
        put(28, enc_b(-4, 0, 1, 5));
        leave_reset();
        run(14);
        expect_reg("t_ctl bne", 10, 32'h0);
        expect_reg("t_ctl blt", 11, 32'h0);
        expect_reg("t_ctl bge nt", 3, 32'd7);
        expect_reg("t_ctl jal link", 4, 32'h0000_0028);
        expect_reg("t_ctl jal skip", 12, 32'h0);
        expect_reg("t_ctl jalr link", 5, 32'h0000_0034);
        expect_val("t_ctl sw", P_DMEM + 0, 32'hFFFF_FFFD);
        expect_reg("t_ctl lw", 6, 32'hFFFF_FFFD);
        expect_val("t_ctl pc", P_PC, 32'h06C);
        drain();

        // randomized add/sub/slt/xor on sign-extended immediates
        for (int k = 0; k < 4; k++) begin
            a = 32'($urandom_range(0, 4095));
            b = 32'($urandom_range(0, 4095));
            sa = {{20{a[11]}}, a[11:0]};
            sb = {{20{b[11]}}, b[11:0]};
            enter_reset($sformatf("t_rnd%0d", k));
            clear_imem();
            put(0, enc_i(a, 0, 0, 1, OPI));
            put(1, enc_i(b, 0, 0, 2, OPI));
            put(2, enc_r(0, 2, 1, 0, 3));
            put(3, enc_r(32, 2, 1, 0, 4));
            put(4, enc_r(0, 2, 1, 2, 5));
            put(5, enc_r(0, 2, 1, 4, 6));
            leave_reset();
            run(6);
            expect_reg($sformatf("t_rnd%0d add", k), 3, sa + sb);
            expect_reg($sformatf("t_rnd%0d sub", k), 4, sa - sb);
            expect_reg($sformatf("t_rnd%0d slt", k), 5, ($signed(sa) < $signed(sb)) ? 32'd1 : 32'd0);
            expect_reg($sformatf("t_rnd%0d xor", k), 6, sa ^ sb);
            drain();
        end

        // pc wrap over an all-zero program
        enter_reset("t_wrap");
        clear_imem();
        leave_reset();
        run(255);
        expect_val("t_wrap pc 255", P_PC, 32'h3FC);
        drain();
        run(1);
        expect_val("t_wrap pc 256", P_PC, 32'h000);
        for (int r = 0; r < 32; r++) expect_reg("t_wrap", r, 32'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
